// File: rtl/rv_multicycle_sequencer.sv
// Control sequencer for the multi-cycle RV32I core: owns PC, IR and the retire
// counter, handshakes with variable-latency memory and raises traps.
module rv_multicycle_sequencer #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR   = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR    = XLEN'(32'h0000_0100),
    parameter int unsigned     MEM_TIMEOUT    = 15,
    parameter int unsigned     CNT_W          = 32,
    parameter bit              HALT_ON_EBREAK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  ls_addr,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  target,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [2:0]       stage,
    output logic [31:0]      load_data,
    output logic             rf_we,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [XLEN-1:0]  mepc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } stage_t;

    stage_t            state;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   target_r;
    logic [XLEN-1:0]   mepc_r;
    logic [31:0]       ir_r;
    logic [31:0]       load_data_r;
    logic              redirect_r;
    logic              rf_we_r;
    logic              trap_r;
    logic              halted_r;
    logic [1:0]        cause_r;
    logic [CNT_W-1:0]  retired_r;
    logic [TO_W-1:0]   to_cnt;

    logic [6:0] opcode;
    logic       op_r, op_i, op_ld, op_st, op_br, op_jal, op_jalr, op_lui, op_auipc;
    logic       op_legal, is_ebreak, wb_write, redirect_now, timed_out;
    logic [1:0] trap_code;

    assign opcode   = ir_r[6:0];
    assign op_r     = (opcode == 7'b0110011);
    assign op_i     = (opcode == 7'b0010011);
    assign op_ld    = (opcode == 7'b0000011);
    assign op_st    = (opcode == 7'b0100011);
    assign op_br    = (opcode == 7'b1100011);
    assign op_jal   = (opcode == 7'b1101111);
    assign op_jalr  = (opcode == 7'b1100111);
    assign op_lui   = (opcode == 7'b0110111);
    assign op_auipc = (opcode == 7'b0010111);
    // Every listed opcode ends in 2'b11, so membership also covers the ir[1:0] check.
    assign op_legal = op_r | op_i | op_ld | op_st | op_br | op_jal | op_jalr | op_lui | op_auipc;
    assign is_ebreak = (ir_r == EBREAK);
    assign wb_write = (op_r | op_i | op_ld | op_jal | op_jalr | op_lui | op_auipc)
                      && (ir_r[11:7] != 5'd0);
    assign redirect_now = op_jal | op_jalr | (op_br & br_taken);
    // A ready arriving on the limit cycle wins over the timeout.
    assign timed_out = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST) && !mem_ready;

    always_comb begin
        trap_code = 2'd0;
        unique case (state)
            S_FETCH, S_MEM: if (timed_out) trap_code = 2'd3;
            S_DECODE:       if (!op_legal && !(HALT_ON_EBREAK && is_ebreak)) trap_code = 2'd1;
            S_EXEC:         if (redirect_now && (target[1:0] != 2'b00)) trap_code = 2'd2;
            default:        trap_code = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc_r        <= RESET_VECTOR;
            ir_r        <= '0;
            load_data_r <= '0;
            target_r    <= '0;
            redirect_r  <= 1'b0;
            rf_we_r     <= 1'b0;
            trap_r      <= 1'b0;
            cause_r     <= 2'd0;
            mepc_r      <= '0;
            halted_r    <= 1'b0;
            retired_r   <= '0;
            to_cnt      <= '0;
        end else begin
            rf_we_r <= 1'b0;
            trap_r  <= 1'b0;
            if (trap_code != 2'd0) begin
                state   <= S_TRAP;
                trap_r  <= 1'b1;
                cause_r <= trap_code;
                mepc_r  <= pc_r;
            end else begin
                unique case (state)
                    S_FETCH: begin
                        if (mem_ready) begin
                            ir_r  <= mem_rdata;
                            state <= S_DECODE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    S_DECODE: begin
                        if (HALT_ON_EBREAK && is_ebreak) begin
                            state    <= S_HALT;
                            halted_r <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        redirect_r <= redirect_now;
                        target_r   <= target;
                        if (op_ld || op_st) begin
                            state  <= S_MEM;
                            to_cnt <= '0;
                        end else begin
                            state   <= S_WB;
                            rf_we_r <= wb_write;
                        end
                    end
                    S_MEM: begin
                        if (mem_ready) begin
                            if (op_ld) load_data_r <= mem_rdata;
                            state   <= S_WB;
                            rf_we_r <= wb_write;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    S_WB: begin
                        pc_r      <= redirect_r ? target_r : pc_plus4;
                        retired_r <= retired_r + CNT_W'(1);
                        state     <= S_FETCH;
                        to_cnt    <= '0;
                    end
                    S_TRAP: begin
                        pc_r   <= TRAP_VECTOR;
                        state  <= S_FETCH;
                        to_cnt <= '0;
                    end
                    S_HALT: state <= S_HALT;
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign mem_req    = !reset && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we     = !reset && (state == S_MEM) && op_st;
    assign mem_addr   = (state == S_MEM) ? ls_addr : pc_r;
    assign ir         = ir_r;
    assign pc         = pc_r;
    assign pc_plus4   = pc_r + XLEN'(4);
    assign stage      = state;
    assign load_data  = load_data_r;
    assign rf_we      = rf_we_r;
    assign trap       = trap_r;
    assign trap_cause = cause_r;
    assign mepc       = mepc_r;
    assign halted     = halted_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Bench for rv_multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is driven and compared.
module tb_rv_multicycle_sequencer;

    localparam int TO = 15;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] TVEC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_rdata, ls_addr, target;
    logic        br_taken;
    logic [31:0] ir, pc, pc_plus4, load_data, mepc, retired;
    logic [2:0]  stage;
    logic        rf_we, trap, halted;
    logic [1:0]  trap_cause;

    rv_multicycle_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TVEC),
        .MEM_TIMEOUT(TO), .CNT_W(32), .HALT_ON_EBREAK(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ls_addr(ls_addr), .br_taken(br_taken), .target(target), .ir(ir),
        .pc(pc), .pc_plus4(pc_plus4), .stage(stage), .load_data(load_data),
        .rf_we(rf_we), .trap(trap), .trap_cause(trap_cause), .mepc(mepc),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stage;
        logic        req, we, rf_we, trap, halted;
        logic [31:0] addr, ir, pc, ld, mepc, ret;
        logic [1:0]  cause;
        logic        rdy, br;
        logic [31:0] rdata, tgt, lsa;
    } cyc_t;

    cyc_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Architectural state of the model
    logic [31:0] m_pc, m_ir, m_ld, m_mepc, m_ret;
    logic [1:0]  m_cause;
    logic        m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        m_pc = 32'h0; m_ir = 0; m_ld = 0; m_mepc = 0; m_ret = 0; m_cause = 0; m_halt = 0;
    endfunction

    function automatic cyc_t base(input logic [2:0] st);
        cyc_t c;
        c.stage = st; c.req = 0; c.we = 0; c.addr = 0; c.rf_we = 0; c.trap = 0;
        c.halted = m_halt; c.ir = m_ir; c.pc = m_pc; c.ld = m_ld; c.mepc = m_mepc;
        c.cause = m_cause; c.ret = m_ret;
        c.rdy = 1'($urandom); c.br = 1'($urandom);
        c.rdata = $urandom; c.tgt = $urandom; c.lsa = $urandom;
        return c;
    endfunction

    function automatic void trap_entry(input logic [1:0] cause);
        cyc_t c;
        m_cause = cause;
        m_mepc  = m_pc;
        c = base(3'd5);
        c.trap = 1'b1;
        q.push_back(c);
        m_pc = TVEC;
    endfunction

    // Expand one instruction into its expected cycle trace.
    task automatic gen(input logic [31:0] instr, input int wf, input logic br,
                       input logic [31:0] tgt, input logic [31:0] lsa,
                       input int wm, input logic [31:0] rdata);
        cyc_t c;
        logic [6:0] op;
        bit ld, st, redir, wr;
        op = instr[6:0];
        for (int k = 0; k <= wf && k < TO; k++) begin
            c = base(3'd0);
            c.req = 1; c.addr = m_pc; c.rdy = (k == wf);
            if (k == wf) c.rdata = instr;
            q.push_back(c);
        end
        if (wf >= TO) begin trap_entry(2'd3); return; end
        m_ir = instr;
        q.push_back(base(3'd1));
        if (instr == EBREAK) begin
            m_halt = 1;
            for (int k = 0; k < 100; k++) q.push_back(base(3'd6));
            return;
        end
        if (!legal(op)) begin trap_entry(2'd1); return; end
        ld = (op == 7'b0000011);
        st = (op == 7'b0100011);
        redir = (op == 7'b1101111) || (op == 7'b1100111) || ((op == 7'b1100011) && br);
        c = base(3'd2);
        c.br = br; c.tgt = tgt;
        q.push_back(c);
        if (redir && tgt[1:0] != 2'b00) begin trap_entry(2'd2); return; end
        if (ld || st) begin
            for (int k = 0; k <= wm && k < TO; k++) begin
                c = base(3'd3);
                c.req = 1; c.we = st; c.addr = lsa; c.lsa = lsa; c.rdy = (k == wm);
                if (k == wm) c.rdata = rdata;
                q.push_back(c);
            end
            if (wm >= TO) begin trap_entry(2'd3); return; end
            if (ld) m_ld = rdata;
        end
        wr = !(st || op == 7'b1100011);
        c = base(3'd4);
        c.rf_we = wr && (instr[11:7] != 5'd0);
        q.push_back(c);
        m_pc = redir ? tgt : m_pc + 32'd4;
        m_ret = m_ret + 1;
    endtask

    // Drive and check up to maxn queued cycles; entered and left at a negedge.
    task automatic run_q(input int maxn);
        cyc_t c;
        for (int i = 0; i < maxn && q.size() > 0; i++) begin
            c = q.pop_front();
            mem_ready = c.rdy; mem_rdata = c.rdata; br_taken = c.br;
            target = c.tgt; ls_addr = c.lsa;
            #1;
            chk("stage", 32'(stage), 32'(c.stage));
            chk("mem_req", 32'(mem_req), 32'(c.req));
            chk("mem_we", 32'(mem_we), 32'(c.we));
            if (c.req) chk("mem_addr", mem_addr, c.addr);
            chk("ir", ir, c.ir);
            chk("pc", pc, c.pc);
            chk("pc_plus4", pc_plus4, c.pc + 32'd4);
            chk("load_data", load_data, c.ld);
            chk("rf_we", 32'(rf_we), 32'(c.rf_we));
            chk("trap", 32'(trap), 32'(c.trap));
            chk("trap_cause", 32'(trap_cause), 32'(c.cause));
            chk("mepc", mepc, c.mepc);
            chk("halted", 32'(halted), 32'(c.halted));
            chk("retired", retired, c.ret);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", retired, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        q.delete();
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10) return 0;
        if (r < 16) return $urandom_range(1, 3);
        if (r == 16) return TO - 1;
        if (r == 17) return TO;
        return $urandom_range(0, 5);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        int cls;
        cls = $urandom_range(0, 10);
        w = $urandom;
        if (cls < 9) begin
            w[6:0] = ops[cls];
            if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        end else begin
            for (int t = 0; t < 100 && (legal(w[6:0]) || w == EBREAK); t++) w = $urandom;
            if (legal(w[6:0]) || w == EBREAK) w = 32'hFFFF_FFFF;
        end
        return w;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 5) == 0) begin
            if (t[1:0] == 2'b00) t[0] = 1'b1;
        end else begin
            t[1:0] = 2'b00;
        end
        return t;
    endfunction

    localparam logic [31:0] ADDI1 = 32'h0050_0093;
    localparam logic [31:0] ADDI2 = 32'h00A0_0113;
    localparam logic [31:0] LW    = 32'h0000_A183;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] JAL1  = 32'h0000_00EF;
    localparam logic [31:0] JAL0  = 32'h0000_006F;

    initial begin
        mem_ready = 0; mem_rdata = 0; ls_addr = 0; br_taken = 0; target = 0;
        model_reset();
        do_reset();

        // addi at reset vector
        gen(ADDI1, 0, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("t1_pc", pc, 32'h4);
        chk("t1_retired", retired, 32'd1);

        // lw with three memory wait cycles
        gen(ADDI2, 0, 1'b0, 0, 0, 0, 0);
        gen(LW, 0, 1'b0, 0, 32'h40, 3, 32'hCAFE_F00D); run_q(1000);
        chk("t2_pc", pc, 32'hC);
        chk("t2_load_data", load_data, 32'hCAFE_F00D);
        chk("t2_retired", retired, 32'd3);

        // branches and a misaligned jump
        gen(BEQ, 0, 1'b1, 32'h20, 0, 0, 0); run_q(1000);
        chk("t3_beq_taken_pc", pc, 32'h20);
        gen(BEQ, 0, 1'b0, 32'h80, 0, 0, 0); run_q(1000);
        chk("t3_beq_nt_pc", pc, 32'h24);
        gen(JAL1, 0, 1'b0, 32'h22, 0, 0, 0); run_q(1000);
        chk("t3_trap_pc", pc, 32'h100);
        chk("t3_mepc", mepc, 32'h24);
        chk("t3_cause", 32'(trap_cause), 32'd2);
        chk("t3_retired", retired, 32'd5);

        // illegal instruction, fetch timeout, ready on the last allowed cycle
        gen(32'hFFFF_FFFF, 0, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("t4_cause", 32'(trap_cause), 32'd1);
        chk("t4_mepc", mepc, 32'h100);
        gen(ADDI1, TO, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("t5_cause", 32'(trap_cause), 32'd3);
        chk("t5_pc", pc, 32'h100);
        gen(ADDI1, TO - 1, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("t5_late_ready_pc", pc, 32'h104);
        chk("t5_retired", retired, 32'd6);

        for (int n = 0; n < 300; n++) begin
            gen(rand_instr(), pick_wait(), 1'($urandom), rand_target(), $urandom,
                pick_wait(), $urandom);
            run_q(1000);
        end

        // pc wrap at the top of the address space
        gen(JAL0, 0, 1'b0, 32'hFFFF_FFFC, 0, 0, 0); run_q(1000);
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        gen(ADDI1, 0, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("wrap_pc_zero", pc, 32'h0);

        // reset while a data request is pending
        gen(LW, 0, 1'b0, 0, 32'h80, TO - 1, 0); run_q(5);
        mem_ready = 1'b0; ls_addr = 32'h80;
        #1;
        chk("t6_pending_stage", 32'(stage), 32'd3);
        chk("t6_pending_req", 32'(mem_req), 32'd1);
        chk("t6_pending_addr", mem_addr, 32'h80);
        do_reset();

        // EBREAK halts until reset
        gen(EBREAK, 0, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("t6_halted", 32'(halted), 32'd1);
        chk("t6_halt_req", 32'(mem_req), 32'd0);
        chk("t6_halt_pc", pc, 32'h0);
        do_reset();
        gen(ADDI1, 0, 1'b0, 0, 0, 0, 0); run_q(1000);
        chk("t6_after_reset_pc", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
